// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over req/gnt/rvalid.
// Latency: req at t with gnt at t and rvalid at t+1 gives ir_valid at t+2; ex_ack at e gives imem_req at e+1.
// Backpressure: ir/pc/ir_valid are held until ex_ack; a misaligned next PC parks the block in FAULT until reset.

`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif

module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic [31:0]              ir,
   output logic [31:0]              pc,
   output logic                     ir_valid,
   input  logic                     ex_ack,
   input  logic [`SEL_PC_WIDTH-1:0] pc_sel,
   input  logic                     br_taken,
   input  logic [31:0]              jump_target,
   input  logic [31:0]              br_target,
   output logic                     fetch_fault,
   output logic [CNT_WIDTH-1:0]     instret
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [`SEL_PC_WIDTH-1:0] SEL_JUMP   = `SEL_PC_WIDTH'(1);
   localparam logic [`SEL_PC_WIDTH-1:0] SEL_BRANCH = `SEL_PC_WIDTH'(2);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      ISSUE,
      FAULT
   } state_t;

   state_t      state;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   // The request address is the architectural PC; only aligned values are ever loaded into it.
   assign imem_addr = pc;

   // Next-PC selection from the decode/execute results; reserved select falls back to sequential.
   always_comb begin
      pc_plus4 = pc + 32'd4;
      next_pc  = pc_plus4;
      if (pc_sel == SEL_JUMP) begin
         // Bit 0 of a JALR target is always cleared.
         next_pc = jump_target & ~32'd1;
      end else if (pc_sel == SEL_BRANCH) begin
         next_pc = br_taken ? br_target : pc_plus4;
      end
   end

   // Fetch FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= REQ;
         pc          <= RESET_PC;
         ir          <= NOP;
         ir_valid    <= 1'b0;
         imem_req    <= 1'b0;
         fetch_fault <= 1'b0;
         instret     <= '0;
      end else begin
         case (state)
            REQ: begin
               // imem_req comes up one cycle after entering REQ from reset;
               // a gnt is only honoured while the request is visible.
               if (imem_req && imem_gnt) begin
                  imem_req <= 1'b0;
                  state    <= WAIT;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  ir       <= imem_rdata;
                  ir_valid <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (ex_ack) begin
                  ir_valid <= 1'b0;
                  instret  <= instret + CNT_WIDTH'(1);
                  if (next_pc[1:0] == 2'b00) begin
                     pc       <= next_pc;
                     imem_req <= 1'b1;
                     state    <= REQ;
                  end else begin
                     // pc is left pointing at the instruction that produced the bad target.
                     fetch_fault <= 1'b1;
                     state       <= FAULT;
                  end
               end
            end
            FAULT: begin
               imem_req    <= 1'b0;
               ir_valid    <= 1'b0;
               fetch_fault <= 1'b1;
            end
            default: state <= FAULT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable gnt/rvalid delays,
// scoreboard of expected {pc, ir} pushed at grant and popped when ir_valid rises.
// Inputs are driven and outputs sampled on the falling edge.

`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif

module tb_fetch_unit;

   localparam int CW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     imem_req;
   logic [31:0]              imem_addr;
   logic                     imem_gnt;
   logic                     imem_rvalid;
   logic [31:0]              imem_rdata;
   logic [31:0]              ir;
   logic [31:0]              pc;
   logic                     ir_valid;
   logic                     ex_ack;
   logic [`SEL_PC_WIDTH-1:0] pc_sel;
   logic                     br_taken;
   logic [31:0]              jump_target;
   logic [31:0]              br_target;
   logic                     fetch_fault;
   logic [CW-1:0]            instret;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_pc;
   logic [CW-1:0] m_instret;

   fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ir(ir), .pc(pc), .ir_valid(ir_valid),
      .ex_ack(ex_ack), .pc_sel(pc_sel), .br_taken(br_taken),
      .jump_target(jump_target), .br_target(br_target),
      .fetch_fault(fetch_fault), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1234_0013);
   endfunction

   function automatic logic [31:0] model_next(input logic [1:0] sel, input logic tk,
                                              input logic [31:0] jt, input logic [31:0] bt,
                                              input logic [31:0] cur);
      case (sel)
         2'd1:    return {jt[31:1], 1'b0};
         2'd2:    return tk ? bt : cur + 32'd4;
         default: return cur + 32'd4;
      endcase
   endfunction

   // One full instruction: request, optional grant stall, read delay, issue, acknowledge.
   task automatic do_fetch(input int gd, input int rd, input logic [1:0] sel, input logic tk,
                           input logic [31:0] jt, input logic [31:0] bt);
      int          n;
      exp_t        e;
      logic [31:0] nxt;
      n = 0;
      while (!imem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, m_pc);
      // Grant stall; a stray rvalid in REQ must be ignored.
      for (int i = 0; i < gd; i++) begin
         imem_rvalid = (i == 0);
         imem_rdata  = 32'hDEAD_0001;
         @(negedge clk);
         imem_rvalid = 1'b0;
         chk("stall_req", 32'(imem_req), 32'd1);
         chk("stall_addr", imem_addr, m_pc);
         chk("stall_irv", 32'(ir_valid), 32'd0);
      end
      imem_gnt = 1'b1;
      sb.push_back('{pc: m_pc, ir: mem_word(m_pc)});
      @(negedge clk);
      imem_gnt = 1'b0;
      chk("req_drop", 32'(imem_req), 32'd0);
      for (int i = 1; i < rd; i++) begin
         @(negedge clk);
         chk("wait_req", 32'(imem_req), 32'd0);
         chk("wait_irv", 32'(ir_valid), 32'd0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(m_pc);
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      chk("ir_valid", 32'(ir_valid), 32'd1);
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("ir", ir, e.ir);
         chk("pc", pc, e.pc);
         if (gd > 0) begin
            // Stray rvalid during ISSUE must not disturb the held instruction.
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_0002;
            @(negedge clk);
            imem_rvalid = 1'b0;
            chk("issue_hold_ir", ir, e.ir);
            chk("issue_hold_v", 32'(ir_valid), 32'd1);
         end
      end
      ex_ack      = 1'b1;
      pc_sel      = sel;
      br_taken    = tk;
      jump_target = jt;
      br_target   = bt;
      nxt = model_next(sel, tk, jt, bt, m_pc);
      @(negedge clk);
      ex_ack = 1'b0;
      m_instret++;
      chk("instret", 32'(instret), 32'(m_instret));
      chk("ack_irv", 32'(ir_valid), 32'd0);
      if (nxt[1:0] == 2'b00) begin
         chk("next_req", 32'(imem_req), 32'd1);
         chk("next_addr", imem_addr, nxt);
         chk("no_fault", 32'(fetch_fault), 32'd0);
         m_pc = nxt;
      end else begin
         chk("fault", 32'(fetch_fault), 32'd1);
         chk("fault_req", 32'(imem_req), 32'd0);
         chk("fault_pc", pc, m_pc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ir", ir, NOP);
      chk("rst_irv", 32'(ir_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      reset = 1'b0;
      m_pc = 32'h0;
      m_instret = '0;
      @(negedge clk);
      chk("post_rst_req", 32'(imem_req), 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);
   endtask

   initial begin
      reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      ex_ack = 1'b0; pc_sel = '0; br_taken = 1'b0; jump_target = 32'h0; br_target = 32'h0;
      m_pc = 32'h0; m_instret = '0;
      @(negedge clk);
      do_reset();

      // gd, rd, sel, taken, jump_target, br_target
      do_fetch(0, 1, 2'd0, 1'b0, 32'h0,         32'h0);    // 0x0 -> 0x4
      do_fetch(3, 2, 2'd1, 1'b0, 32'h100,       32'h0);    // stall, -> 0x100
      do_fetch(0, 1, 2'd2, 1'b1, 32'h0,         32'h80);   // taken -> 0x80
      do_fetch(0, 1, 2'd1, 1'b0, 32'h100,       32'h0);    // -> 0x100
      do_fetch(1, 3, 2'd2, 1'b0, 32'h0,         32'h80);   // not taken -> 0x104
      do_fetch(0, 1, 2'd1, 1'b0, 32'h2001,      32'h0);    // -> 0x2000
      do_fetch(0, 1, 2'd3, 1'b1, 32'h0,         32'h40);   // reserved = PLUS4 -> 0x2004
      do_fetch(0, 1, 2'd1, 1'b0, 32'hFFFF_FFFC, 32'h0);    // -> 0xFFFFFFFC
      do_fetch(0, 1, 2'd0, 1'b0, 32'h0,         32'h0);    // wraps -> 0x0
      do_fetch(0, 1, 2'd1, 1'b0, 32'h0000_0102, 32'h0);    // misaligned -> FAULT

      // FAULT is sticky and issues nothing, even with gnt/rvalid wiggling.
      imem_gnt = 1'b1;
      imem_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fault_hold_req", 32'(imem_req), 32'd0);
         chk("fault_hold_flag", 32'(fetch_fault), 32'd1);
         chk("fault_hold_pc", pc, 32'h0);
         chk("fault_hold_irv", 32'(ir_valid), 32'd0);
      end
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      do_reset();

      // Reset while waiting for data, with rvalid in the same cycle: data dropped.
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      chk("w_req_drop", 32'(imem_req), 32'd0);
      reset = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      reset = 1'b0;
      imem_rvalid = 1'b0;
      chk("wrst_ir", ir, NOP);
      chk("wrst_irv", 32'(ir_valid), 32'd0);
      chk("wrst_req", 32'(imem_req), 32'd0);
      m_pc = 32'h0;
      m_instret = '0;
      @(negedge clk);
      chk("wrst_reissue", 32'(imem_req), 32'd1);
      chk("wrst_addr", imem_addr, 32'h0);

      // Sixteen sequential acks wrap the 4-bit retired counter.
      for (int i = 0; i < 16; i++) begin
         do_fetch(0, 1, 2'd0, 1'b0, 32'h0, 32'h0);
      end
      chk("instret_wrap", 32'(instret), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
